shark_scheduler: RTL and testbench

Owns the lifecycle of up to N_SLOTS shark obstacles for the Yoshi game: spawns them at a fixed frame interval at pseudo-random heights, scrolls them left once per frame, retires them when they leave the screen, and detects collision with Yoshi. It sits between the VGA frame-tick source and the per-slot shark renderers, which consume its x/y/active outputs. It also drives the game-over condition and the dodge score.

---
 rtl/shark_scheduler_pkg.sv | 15 +
 rtl/shark_scheduler_lfsr8.sv | 20 ++
 rtl/shark_scheduler.sv | 138 +++++++++++++
 tb/tb_shark_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shark_scheduler_pkg.sv
// Shared constants and types for the shark obstacle scheduler.
// Screen limits, sprite size, FSM states and the LFSR seed/taps live here.
package shark_scheduler_pkg;

  localparam int MAX_X    = 640;
  localparam int MAX_Y    = 480;
  localparam int SPRITE_W = 16;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

endpackage

// File: rtl/shark_scheduler_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with an asynchronous-reset seed.
// Only the low seven bits leave the block; bit 7 feeds back internally.
module lfsr8
  import shark_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] rnd
);

  logic [7:0] state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LFSR_SEED;
    else       state <= {state[6:0], ^(state & LFSR_TAPS)};
  end

  assign rnd = state[6:0];

endmodule

// File: rtl/shark_scheduler.sv
// Spawns, scrolls, retires and collision-checks shark obstacles per frame.
// Drives per-slot sprite positions, the hit pulse, game_over and the score.
module shark_scheduler #(
  parameter int N_SLOTS      = 4,
  parameter int SPAWN_PERIOD = 60,
  parameter int SPEED        = 2,
  parameter int START_X      = 624,
  parameter int Y_MIN        = 300,
  parameter int SPRITE_W     = shark_scheduler_pkg::SPRITE_W
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic [9:0]             y_x,
  input  logic [9:0]             y_y,
  output logic [10*N_SLOTS-1:0]  shark_x,
  output logic [10*N_SLOTS-1:0]  shark_y,
  output logic [N_SLOTS-1:0]     shark_active,
  output logic                   hit,
  output logic                   game_over,
  output logic [7:0]             score
);
  import shark_scheduler_pkg::*;

  localparam int              TW         = $clog2(SPAWN_PERIOD + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SPAWN_PERIOD - 1);
  localparam logic [9:0]      SPEED_V    = 10'(SPEED);
  localparam logic [9:0]      START_V    = 10'(START_X);
  localparam logic [9:0]      YMIN_V     = 10'(Y_MIN);
  localparam logic [10:0]     SPRITE_V   = 11'(SPRITE_W);

  state_t             state;
  logic [TW-1:0]      timer;
  logic [6:0]         rnd;
  logic [9:0]         xs [N_SLOTS];
  logic [9:0]         ys [N_SLOTS];
  logic [N_SLOTS-1:0] active;
  logic               check_pending;

  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] spawn_onehot;
  logic [N_SLOTS-1:0] retire;
  logic [N_SLOTS-1:0] overlap;
  logic               spawn_now;
  logic [7:0]         score_next;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  // Lowest free slot wins: isolate the least significant set bit of the free mask.
  assign free         = ~active;
  assign spawn_onehot = free & (~free + N_SLOTS'(1));
  assign spawn_now    = (timer == TIMER_LAST) && (|free);

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    assign retire[i]  = active[i] && (xs[i] < SPEED_V);
    assign overlap[i] = active[i]
                     && ({1'b0, xs[i]} < ({1'b0, y_x} + SPRITE_V))
                     && ({1'b0, y_x}   < ({1'b0, xs[i]} + SPRITE_V))
                     && ({1'b0, ys[i]} < ({1'b0, y_y} + SPRITE_V))
                     && ({1'b0, y_y}   < ({1'b0, ys[i]} + SPRITE_V));
    assign shark_x[10*i +: 10] = xs[i];
    assign shark_y[10*i +: 10] = ys[i];
  end

  assign shark_active = active;

  always_comb begin
    score_next = score;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (retire[i] && (score_next != 8'hFF)) score_next = score_next + 8'd1;
    end
  end

  // Collision is judged the cycle after a tick, once the moved positions are visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      hit           <= 1'b0;
      game_over     <= 1'b0;
      score         <= '0;
      check_pending <= 1'b0;
      active        <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else begin
      hit           <= 1'b0;
      check_pending <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= RUN;
            game_over <= 1'b0;
            timer     <= '0;
            score     <= '0;
            active    <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
              xs[i] <= '0;
              ys[i] <= '0;
            end
          end
        end
        RUN: begin
          if (check_pending && (|overlap)) begin
            state     <= OVER;
            hit       <= 1'b1;
            game_over <= 1'b1;
          end else if (frame_tick) begin
            check_pending <= 1'b1;
            score         <= score_next;
            if (timer != TIMER_LAST) timer <= timer + TW'(1);
            else if (|free)          timer <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
              if (spawn_now && spawn_onehot[i]) begin
                xs[i]     <= START_V;
                ys[i]     <= YMIN_V + {3'b000, rnd};
                active[i] <= 1'b1;
              end else if (retire[i]) begin
                active[i] <= 1'b0;
              end else if (active[i]) begin
                xs[i] <= xs[i] - SPEED_V;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shark_scheduler.sv
// Randomised bench for shark_scheduler against a frame-level game model.
// Directed phases walk the spawn, retire, full-slot, collision and reset scenarios.
module tb_shark_scheduler;

  localparam int N            = 4;
  localparam int SPAWN_PERIOD = 60;
  localparam int SPEED        = 2;
  localparam int START_X      = 624;
  localparam int Y_MIN        = 300;
  localparam int SW           = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_tick;
  logic            start;
  logic [9:0]      y_x;
  logic [9:0]      y_y;
  logic [10*N-1:0] shark_x;
  logic [10*N-1:0] shark_y;
  logic [N-1:0]    shark_active;
  logic            hit;
  logic            game_over;
  logic [7:0]      score;

  int testCount = 0;
  int failCount = 0;

  // Model state: 0 idle, 1 running, 2 game over.
  int         mState;
  int         mx [N];
  int         my [N];
  bit         ma [N];
  int         mScore;
  int         mTimer;
  bit         mPending;
  bit         mHit;
  bit         mGameOver;
  logic [7:0] mLfsr;

  shark_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .y_x          (y_x),
    .y_y          (y_y),
    .shark_x      (shark_x),
    .shark_y      (shark_y),
    .shark_active (shark_active),
    .hit          (hit),
    .game_over    (game_over),
    .score        (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsrNext(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic bit modelOverlap();
    for (int i = 0; i < N; i++) begin
      if (ma[i] && mx[i] < int'(y_x) + SW && int'(y_x) < mx[i] + SW &&
          my[i] < int'(y_y) + SW && int'(y_y) < my[i] + SW) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    mState = 0; mScore = 0; mTimer = 0; mPending = 0; mHit = 0; mGameOver = 0;
    mLfsr = 8'hA5;
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; ma[i] = 0; end
  endtask

  // Advances the model by one clock given the inputs about to be sampled.
  task automatic modelStep(input bit tick, input bit st);
    bit pendingNow;
    int lowFree;
    pendingNow = mPending;
    mPending = 0;
    mHit = 0;
    if (mState != 1) begin
      if (st) begin
        mState = 1; mScore = 0; mTimer = 0; mGameOver = 0;
        for (int i = 0; i < N; i++) ma[i] = 0;
      end
    end else if (pendingNow && modelOverlap()) begin
      mState = 2; mHit = 1; mGameOver = 1;
    end else if (tick) begin
      mPending = 1;
      lowFree = -1;
      for (int i = 0; i < N; i++) if (!ma[i] && lowFree < 0) lowFree = i;
      for (int i = 0; i < N; i++) begin
        if (ma[i]) begin
          if (mx[i] < SPEED) begin
            ma[i] = 0;
            if (mScore < 255) mScore++;
          end else mx[i] -= SPEED;
        end
      end
      if (mTimer < SPAWN_PERIOD - 1) mTimer++;
      else if (lowFree >= 0) begin
        ma[lowFree] = 1; mx[lowFree] = START_X; my[lowFree] = Y_MIN + (mLfsr & 8'h7F);
        mTimer = 0;
      end
    end
    mLfsr = lfsrNext(mLfsr);
  endtask

  task automatic checkOutput();
    logic [N-1:0] expActive;
    for (int i = 0; i < N; i++) expActive[i] = ma[i];
    check("active", 32'(shark_active), 32'(expActive));
    for (int i = 0; i < N; i++) begin
      if (ma[i]) begin
        check($sformatf("x[%0d]", i), 32'(shark_x[10*i +: 10]), mx[i]);
        check($sformatf("y[%0d]", i), 32'(shark_y[10*i +: 10]), my[i]);
      end
    end
    check("hit", 32'(hit), 32'(mHit));
    check("game_over", 32'(game_over), 32'(mGameOver));
    check("score", 32'(score), mScore);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_x"}, 32'(shark_x == '0), 1);
    check({tag, "_y"}, 32'(shark_y == '0), 1);
    check({tag, "_active"}, 32'(shark_active), 0);
    check({tag, "_hit"}, 32'(hit), 0);
    check({tag, "_game_over"}, 32'(game_over), 0);
    check({tag, "_score"}, 32'(score), 0);
  endtask

  task automatic applyStimulus(input bit tick, input bit st);
    frame_tick = tick;
    start = st;
    modelStep(tick, st);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start = 1'b0;
    checkOutput();
  endtask

  // One frame: a tick then 1-3 quiet cycles, with occasional ignored start pulses in RUN.
  task automatic tickFrame(input bit randYoshi);
    if (randYoshi) begin
      y_x = 10'($urandom_range(0, 620));
      y_y = 10'($urandom_range(0, 200));
    end
    applyStimulus(1'b1, 1'b0);
    repeat ($urandom_range(1, 3))
      applyStimulus(1'b0, (mState == 1) && ($urandom_range(0, 7) == 0));
  endtask

  task automatic runTicks(input int n, input bit randYoshi);
    for (int k = 0; k < n; k++) tickFrame(randYoshi);
  endtask

  task automatic asyncReset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues(tag);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; y_x = '0; y_y = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores ticks; start together with a tick starts the game and drops the tick.
    runTicks(3, 1'b1);
    check("idle_active", 32'(shark_active), 0);
    applyStimulus(1'b1, 1'b1);
    runTicks(59, 1'b1);
    check("no_spawn_at_59", 32'(shark_active), 0);
    runTicks(1, 1'b1);
    check("spawn_slot0", 32'(shark_active), 32'b0001);
    check("spawn_x", 32'(shark_x[9:0]), START_X);
    check("spawn_y_range", 32'(shark_y[9:0] >= 10'd300 && shark_y[9:0] <= 10'd427), 1);
    runTicks(120, 1'b1);
    check("three_active", 32'(shark_active), 32'b0111);

    asyncReset("midrun");
    applyStimulus(1'b0, 1'b1);
    check("restart_score", 32'(score), 0);
    check("restart_game_over", 32'(game_over), 0);

    // Fill all four slots, hold the timer, then reuse slot 0 the tick after it retires.
    runTicks(300, 1'b1);
    check("full", 32'(shark_active), 32'b1111);
    runTicks(72, 1'b1);
    check("slot0_x0", 32'(shark_x[9:0]), 0);
    check("slot0_still_active", 32'(shark_active[0]), 1);
    runTicks(1, 1'b1);
    check("retired", 32'(shark_active), 32'b1110);
    check("score_one", 32'(score), 1);
    runTicks(1, 1'b1);
    check("respawn_slot0", 32'(shark_active), 32'b1111);
    check("respawn_x", 32'(shark_x[9:0]), START_X);

    // Collision at x=114 with Yoshi at x=100; x=116 is edge-adjacent only.
    asyncReset("pre_collide");
    applyStimulus(1'b0, 1'b1);
    runTicks(60, 1'b1);
    y_x = 10'd100;
    y_y = 10'(my[0] + 10);
    runTicks(254, 1'b0);
    check("at_116", 32'(shark_x[9:0]), 116);
    check("no_hit_116", 32'(game_over), 0);
    applyStimulus(1'b1, 1'b0);
    check("at_114", 32'(shark_x[9:0]), 114);
    check("hit_not_yet", 32'(hit), 0);
    applyStimulus(1'b0, 1'b0);
    check("hit_pulse", 32'(hit), 1);
    check("game_over_set", 32'(game_over), 1);
    applyStimulus(1'b0, 1'b0);
    check("hit_one_cycle", 32'(hit), 0);
    runTicks(3, 1'b0);
    check("frozen_x", 32'(shark_x[9:0]), 114);
    check("over_held", 32'(game_over), 1);

    // Restart from OVER with a simultaneous tick, then overlap by one pixel at x=116.
    applyStimulus(1'b1, 1'b1);
    check("over_restart", 32'(game_over), 0);
    check("over_restart_active", 32'(shark_active), 0);
    runTicks(60, 1'b1);
    y_x = 10'd101;
    y_y = 10'(my[0]);
    runTicks(253, 1'b0);
    check("at_118", 32'(shark_x[9:0]), 118);
    check("no_hit_118", 32'(game_over), 0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    check("hit_115_case", 32'(hit), 1);
    check("x_116", 32'(shark_x[9:0]), 116);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
